// File: rtl/cv32e40p_tmr_reconfig_ctrl_if.sv
// Handshake bundle between the TMR reconfiguration controller and the
// breakage monitors, voter and core halt logic. Signal names keep the controller's view.
interface cv32e40p_tmr_reconfig_ctrl_if;
  logic [2:0] is_broken_i;
  logic [2:0] force_broken_i;
  logic       dmr_mismatch_i;
  logic       halt_ack_i;
  logic       halt_req_o;
  logic [2:0] replica_en_o;
  logic [2:0] set_broken_o;
  logic [1:0] mode_o;
  logic       reconfig_done_o;
  logic       fatal_o;

  modport master (
    input  is_broken_i, force_broken_i, dmr_mismatch_i, halt_ack_i,
    output halt_req_o, replica_en_o, set_broken_o, mode_o, reconfig_done_o, fatal_o
  );

  modport slave (
    output is_broken_i, force_broken_i, dmr_mismatch_i, halt_ack_i,
    input  halt_req_o, replica_en_o, set_broken_o, mode_o, reconfig_done_o, fatal_o
  );
endinterface

// File: rtl/cv32e40p_tmr_reconfig_ctrl.sv
// TMR reconfiguration controller: degrades TMR -> DMR -> SIMPLEX -> FAIL on
// replica faults, halting the core around each replica-mask commit.
module cv32e40p_tmr_reconfig_ctrl #(
  parameter int unsigned HALT_TIMEOUT  = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_BIT       = 5
) (
  input  logic                                clk_gated,
  input  logic                                rst_n,
  cv32e40p_tmr_reconfig_ctrl_if.master        ctrl_if
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] HALT   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] FAIL   = 2'd3;

  localparam logic [1:0] MODE_DMR  = 2'b01;
  localparam logic [1:0] MODE_FAIL = 2'b11;

  localparam logic [CNT_BIT-1:0] HALT_LAST   = CNT_BIT'(HALT_TIMEOUT - 1);
  localparam logic [CNT_BIT-1:0] SETTLE_LAST = CNT_BIT'(SETTLE_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic [2:0]         en_q, en_d;
  logic [2:0]         pend_q, pend_d;
  logic [2:0]         setb_q, setb_d;
  logic [1:0]         mode_q, mode_d;
  logic               done_q, done_d;
  logic               fatal_q, fatal_d;

  logic [2:0]         new_v;
  logic [2:0]         commit_mask;
  logic [1:0]         live_cnt;

  // Already-excluded replicas are masked so they cannot retrigger a halt.
  assign new_v       = (ctrl_if.is_broken_i | ctrl_if.force_broken_i) & en_q;
  assign commit_mask = en_q & ~(pend_q | new_v);
  assign live_cnt    = {1'b0, commit_mask[0]} + {1'b0, commit_mask[1]} + {1'b0, commit_mask[2]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    pend_d  = pend_q | new_v;
    mode_d  = mode_q;
    done_d  = 1'b0;
    fatal_d = fatal_q;

    case (state_q)
      RUN: begin
        if ((mode_q == MODE_DMR) && ctrl_if.dmr_mismatch_i) begin
          state_d = FAIL;
        end else if (new_v != 3'b000) begin
          state_d = HALT;
          cnt_d   = '0;
        end
      end
      HALT: begin
        if (ctrl_if.halt_ack_i) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == HALT_LAST) begin
          state_d = FAIL;
        end else begin
          cnt_d = cnt_q + CNT_BIT'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          en_d    = commit_mask;
          pend_d  = '0;
          done_d  = 1'b1;
          // Mode encoding is 3 minus the number of surviving replicas.
          mode_d  = 2'd3 - live_cnt;
          cnt_d   = '0;
          state_d = (commit_mask == 3'b000) ? FAIL : RUN;
        end else begin
          cnt_d = cnt_q + CNT_BIT'(1);
        end
      end
      default: ;
    endcase

    if (state_d == FAIL) begin
      en_d    = '0;
      pend_d  = '0;
      mode_d  = MODE_FAIL;
      fatal_d = 1'b1;
    end

    setb_d = ~en_d | pend_d;
  end

  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      en_q    <= '1;
      pend_q  <= '0;
      setb_q  <= '0;
      mode_q  <= '0;
      done_q  <= 1'b0;
      fatal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      setb_q  <= setb_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      fatal_q <= fatal_d;
    end
  end

  assign ctrl_if.halt_req_o      = (state_q != RUN);
  assign ctrl_if.replica_en_o    = en_q;
  assign ctrl_if.set_broken_o    = setb_q;
  assign ctrl_if.mode_o          = mode_q;
  assign ctrl_if.reconfig_done_o = done_q;
  assign ctrl_if.fatal_o         = fatal_q;

endmodule

// File: tb/tb_cv32e40p_tmr_reconfig_ctrl.sv
// Directed scoreboard bench for the TMR reconfiguration controller.
module tb_cv32e40p_tmr_reconfig_ctrl;

  localparam int unsigned HALT_TIMEOUT  = 16;
  localparam int unsigned SETTLE_CYCLES = 4;

  typedef struct packed {
    logic       hr;
    logic [2:0] en;
    logic [2:0] sb;
    logic [1:0] mode;
    logic       done;
    logic       fatal;
  } out_t;

  typedef struct {
    string tag;
    out_t  exp;
  } sb_item_t;

  logic        clk_gated = 1'b0;
  logic        rst_n     = 1'b1;
  int unsigned checks    = 0;
  int unsigned errors    = 0;
  int unsigned lat;
  sb_item_t    sb_q[$];

  cv32e40p_tmr_reconfig_ctrl_if bus();

  cv32e40p_tmr_reconfig_ctrl #(
    .HALT_TIMEOUT (HALT_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_BIT      (5)
  ) dut (
    .clk_gated(clk_gated),
    .rst_n    (rst_n),
    .ctrl_if  (bus.master)
  );

  always #5 clk_gated = ~clk_gated;

  function automatic out_t observe();
    return {bus.halt_req_o, bus.replica_en_o, bus.set_broken_o, bus.mode_o,
            bus.reconfig_done_o, bus.fatal_o};
  endfunction

  task automatic tick();
    @(posedge clk_gated);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic hr, input logic [2:0] en,
                            input logic [2:0] sb, input logic [1:0] mode,
                            input logic done, input logic fatal);
    sb_item_t it;
    it.tag = tag;
    it.exp = {hr, en, sb, mode, done, fatal};
    sb_q.push_back(it);
  endtask

  task automatic check();
    sb_item_t it;
    out_t     act;
    act = observe();
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %b, no expected entry", act);
      return;
    end
    it = sb_q.pop_front();
    assert (act === it.exp) else begin
      errors++;
      $error("FAIL %s: observed hr=%b en=%b sb=%b mode=%b done=%b fatal=%b, expected hr=%b en=%b sb=%b mode=%b done=%b fatal=%b",
             it.tag, act.hr, act.en, act.sb, act.mode, act.done, act.fatal,
             it.exp.hr, it.exp.en, it.exp.sb, it.exp.mode, it.exp.done, it.exp.fatal);
    end
  endtask

  task automatic check_int(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    assert (act == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Bounded wait for reconfig_done_o (want_fatal=0) or fatal_o (want_fatal=1).
  task automatic wait_for(input string tag, input bit want_fatal, input int unsigned budget,
                          output int unsigned n);
    logic seen;
    n    = 0;
    seen = want_fatal ? bus.fatal_o : bus.reconfig_done_o;
    while ((n < budget) && (seen !== 1'b1)) begin
      tick();
      n++;
      seen = want_fatal ? bus.fatal_o : bus.reconfig_done_o;
    end
    checks++;
    assert (seen === 1'b1) else begin
      errors++;
      $error("FAIL %s_timeout: observed %b after %0d cycles, expected 1", tag, seen, n);
    end
  endtask

  task automatic clear_inputs();
    bus.is_broken_i    = 3'b000;
    bus.force_broken_i = 3'b000;
    bus.dmr_mismatch_i = 1'b0;
    bus.halt_ack_i     = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    clear_inputs();
    rst_n = 1'b0;
    #2;
    expect_out(tag, 1'b0, 3'b111, 3'b000, 2'b00, 1'b0, 1'b0);
    check();
    @(negedge clk_gated);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    clear_inputs();
    #1;
    do_reset("reset_init");

    // T1: single fault in TMR, ack three cycles into the halt.
    bus.is_broken_i = 3'b010;
    expect_out("t1_halt_req", 1'b1, 3'b111, 3'b010, 2'b00, 1'b0, 1'b0);
    tick();
    check();
    bus.is_broken_i = 3'b000;
    tick();
    tick();
    bus.halt_ack_i = 1'b1;
    expect_out("t1_settle", 1'b1, 3'b111, 3'b010, 2'b00, 1'b0, 1'b0);
    tick();
    check();
    bus.halt_ack_i = 1'b0;
    wait_for("t1_done", 1'b0, 20, lat);
    check_int("t1_settle_latency", lat, SETTLE_CYCLES);
    expect_out("t1_commit", 1'b0, 3'b101, 3'b010, 2'b01, 1'b1, 1'b0);
    check();
    expect_out("t1_after_commit", 1'b0, 3'b101, 3'b010, 2'b01, 1'b0, 1'b0);
    tick();
    check();

    // T2: DMR mismatch together with a new fault goes straight to FAIL.
    bus.dmr_mismatch_i = 1'b1;
    bus.is_broken_i    = 3'b001;
    expect_out("t2_fail", 1'b1, 3'b000, 3'b111, 2'b11, 1'b0, 1'b1);
    tick();
    check();
    bus.dmr_mismatch_i = 1'b0;
    bus.is_broken_i    = 3'b111;
    bus.halt_ack_i     = 1'b1;
    tick();
    tick();
    expect_out("t2_fail_absorbing", 1'b1, 3'b000, 3'b111, 2'b11, 1'b0, 1'b1);
    check();

    // T3: second fault during SETTLE folds into the same commit.
    do_reset("reset_t3");
    bus.is_broken_i = 3'b001;
    expect_out("t3_halt_req", 1'b1, 3'b111, 3'b001, 2'b00, 1'b0, 1'b0);
    tick();
    check();
    bus.is_broken_i = 3'b000;
    bus.halt_ack_i  = 1'b1;
    tick();
    bus.halt_ack_i  = 1'b0;
    tick();
    bus.is_broken_i = 3'b100;
    expect_out("t3_settle_accum", 1'b1, 3'b111, 3'b101, 2'b00, 1'b0, 1'b0);
    tick();
    check();
    bus.is_broken_i = 3'b000;
    wait_for("t3_done", 1'b0, 20, lat);
    expect_out("t3_commit", 1'b0, 3'b010, 3'b101, 2'b10, 1'b1, 1'b0);
    check();
    tick();
    tick();
    tick();
    expect_out("t3_single_pulse", 1'b0, 3'b010, 3'b101, 2'b10, 1'b0, 1'b0);
    check();

    // T4: two replicas fail in one cycle, TMR straight to SIMPLEX.
    do_reset("reset_t4");
    bus.is_broken_i = 3'b011;
    expect_out("t4_halt_req", 1'b1, 3'b111, 3'b011, 2'b00, 1'b0, 1'b0);
    tick();
    check();
    bus.is_broken_i = 3'b000;
    bus.halt_ack_i  = 1'b1;
    tick();
    bus.halt_ack_i  = 1'b0;
    wait_for("t4_done", 1'b0, 20, lat);
    expect_out("t4_commit", 1'b0, 3'b100, 3'b011, 2'b10, 1'b1, 1'b0);
    check();
    bus.is_broken_i = 3'b011;
    expect_out("t4_masked_fault", 1'b0, 3'b100, 3'b011, 2'b10, 1'b0, 1'b0);
    tick();
    check();
    bus.is_broken_i = 3'b100;
    expect_out("t4_simplex_halt", 1'b1, 3'b100, 3'b111, 2'b10, 1'b0, 1'b0);
    tick();
    check();
    bus.is_broken_i = 3'b000;
    bus.halt_ack_i  = 1'b1;
    tick();
    bus.halt_ack_i  = 1'b0;
    wait_for("t4_last_done", 1'b0, 20, lat);
    expect_out("t4_empty_mask_fail", 1'b1, 3'b000, 3'b111, 2'b11, 1'b1, 1'b1);
    check();

    // T5a: ack never arrives, FAIL after exactly HALT_TIMEOUT HALT cycles.
    do_reset("reset_t5a");
    bus.force_broken_i = 3'b100;
    expect_out("t5a_halt_req", 1'b1, 3'b111, 3'b100, 2'b00, 1'b0, 1'b0);
    tick();
    check();
    bus.force_broken_i = 3'b000;
    wait_for("t5a_fatal", 1'b1, 40, lat);
    check_int("t5a_timeout_cycles", lat, HALT_TIMEOUT);
    expect_out("t5a_fail", 1'b1, 3'b000, 3'b111, 2'b11, 1'b0, 1'b1);
    check();

    // T5b: ack on the last HALT cycle wins over the timeout.
    do_reset("reset_t5b");
    bus.force_broken_i = 3'b100;
    tick();
    bus.force_broken_i = 3'b000;
    for (int unsigned i = 0; i < HALT_TIMEOUT - 1; i++) tick();
    expect_out("t5b_last_halt_cycle", 1'b1, 3'b111, 3'b100, 2'b00, 1'b0, 1'b0);
    check();
    bus.halt_ack_i = 1'b1;
    expect_out("t5b_settle_not_fail", 1'b1, 3'b111, 3'b100, 2'b00, 1'b0, 1'b0);
    tick();
    check();
    bus.halt_ack_i = 1'b0;
    wait_for("t5b_done", 1'b0, 20, lat);
    expect_out("t5b_commit", 1'b0, 3'b011, 3'b100, 2'b01, 1'b1, 1'b0);
    check();

    // T6: reset mid-SETTLE, then a full sequence from scratch.
    do_reset("reset_t6_pre");
    bus.is_broken_i = 3'b010;
    tick();
    bus.is_broken_i = 3'b000;
    bus.halt_ack_i  = 1'b1;
    tick();
    bus.halt_ack_i  = 1'b0;
    tick();
    do_reset("t6_async_reset");
    bus.is_broken_i = 3'b001;
    expect_out("t6_restart_halt", 1'b1, 3'b111, 3'b001, 2'b00, 1'b0, 1'b0);
    tick();
    check();
    bus.is_broken_i = 3'b000;
    bus.halt_ack_i  = 1'b1;
    tick();
    bus.halt_ack_i  = 1'b0;
    wait_for("t6_done", 1'b0, 20, lat);
    check_int("t6_settle_latency", lat, SETTLE_CYCLES);
    expect_out("t6_commit", 1'b0, 3'b110, 3'b001, 2'b01, 1'b1, 1'b0);
    check();

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
